c1_zone_decode: RTL

//  Upstream stage of the C1 wait-state generator. It registers the 68K address at the start of each bus cycle.
//  It produces stable active-low zone selects (ROM/WRAM/PORT/IO/CARD/SYSTEM) that are held for the whole cycle.
//  It also runs a DTACK watchdog: if a cycle is never acknowledged, it asserts nBERR.
//  It sits between the 68K bus pins and the wait/DTACK logic in the System block.

---
 rtl/c1_zone_decode.sv | 138 +++++++++++++
 1 files changed

// File: rtl/c1_zone_decode.sv
// C1 address zone decoder: latches active-low zone selects for each 68K bus
// cycle and raises nBERR if the cycle is not acknowledged in time.
module c1_zone_decode #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        CLK_68KCLK,
  input  logic        nRESET,
  input  logic [23:1] M68K_ADDR,
  input  logic        nAS,
  input  logic        nDTACK,
  output logic        nROM_ZONE,
  output logic        nWRAM_ZONE,
  output logic        nPORT_ZONE,
  output logic        nIO_ZONE,
  output logic        nCARD_ZONE,
  output logic        nSYSTEM_ZONE,
  output logic        ZONE_HIT,
  output logic        nBERR
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ACTIVE, BERR, RELEASE} state_t;

  // All fields active low.
  typedef struct packed {
    logic rom;
    logic wram;
    logic port;
    logic io;
    logic card;
    logic sys;
  } zoneSel_t;

  localparam zoneSel_t SEL_NONE = '{default: 1'b1};

  function automatic zoneSel_t decodeZone(input logic [3:0] code);
    zoneSel_t z;
    z = SEL_NONE;
    case (code)
      4'h0:                      z.rom  = 1'b0;
      4'h1:                      z.wram = 1'b0;
      4'h2:                      z.port = 1'b0;
      4'h3:                      z.io   = 1'b0;
      4'h8, 4'h9, 4'hA, 4'hB:    z.card = 1'b0;
      4'hC:                      z.sys  = 1'b0;
      default:                   z      = SEL_NONE;
    endcase
    return z;
  endfunction

  state_t           state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  zoneSel_t         selReg, selNext;
  logic             berrN, berrNext;
  logic             hitReg;

  // Only A23..A20 take part in decoding.
  logic unusedAddrBits;
  assign unusedAddrBits = ^M68K_ADDR[19:1];

  always_ff @(posedge CLK_68KCLK) begin
    if (!nRESET) begin
      state  <= IDLE;
      cnt    <= '0;
      selReg <= SEL_NONE;
      berrN  <= 1'b1;
      hitReg <= 1'b0;
    end else begin
      state  <= stateNext;
      cnt    <= cntNext;
      selReg <= selNext;
      berrN  <= berrNext;
      hitReg <= ~&selNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    selNext   = selReg;
    berrNext  = berrN;
    case (state)
      IDLE: begin
        if (!nAS) begin
          selNext   = decodeZone(M68K_ADDR[23:20]);
          cntNext   = CNT_W'(1);
          stateNext = ACTIVE;
        end
      end
      ACTIVE: begin
        // Priority: strobe release, then acknowledge, then timeout.
        if (nAS) begin
          selNext   = SEL_NONE;
          cntNext   = '0;
          stateNext = RELEASE;
        end else if (!nDTACK) begin
          cntNext   = cnt;
        end else if (cnt == CNT_MAX) begin
          berrNext  = 1'b0;
          stateNext = BERR;
        end else begin
          cntNext   = cnt + 1'b1;
        end
      end
      BERR: begin
        if (nAS) begin
          berrNext  = 1'b1;
          selNext   = SEL_NONE;
          cntNext   = '0;
          stateNext = RELEASE;
        end
      end
      RELEASE: begin
        // Forced one-cycle gap; a low strobe here is not a new cycle yet.
        selNext   = SEL_NONE;
        stateNext = IDLE;
      end
      default: begin
        selNext   = SEL_NONE;
        berrNext  = 1'b1;
        cntNext   = '0;
        stateNext = IDLE;
      end
    endcase
  end

  assign nROM_ZONE    = selReg.rom;
  assign nWRAM_ZONE   = selReg.wram;
  assign nPORT_ZONE   = selReg.port;
  assign nIO_ZONE     = selReg.io;
  assign nCARD_ZONE   = selReg.card;
  assign nSYSTEM_ZONE = selReg.sys;
  assign ZONE_HIT     = hitReg;
  assign nBERR        = berrN;

endmodule
